// File: rtl/unsharp_mask_core_if.sv
// -----------------------------------------------------------------------------
// unsharp_mask_core_if
// Purpose : groups the four single-port RAM buses used by unsharp_mask_core.
//           The core is the master: it drives addresses and strobes and
//           receives read data. The RAM models / wrappers use the slave side.
// Signals :
//   img_p0_*       image read port     (rd_data in, addr_en/addr_data/rd_en out)
//   kernelX_p0_*   X-tap read port     (rd_data in, addr_en/addr_data/rd_en out)
//   kernelY_p0_*   Y-tap read port     (rd_data in, addr_en/addr_data/rd_en out)
//   mask_img_p0_*  result write port   (wr_data/addr_en/addr_data/wr_en out)
// -----------------------------------------------------------------------------
interface unsharp_mask_core_if #(
  parameter int ADDR_W  = 10,
  parameter int KADDR_W = 3
);
  logic [31:0]         img_p0_rd_data;
  logic                img_p0_addr_en;
  logic [ADDR_W-1:0]   img_p0_addr_data;
  logic                img_p0_rd_en;

  logic [31:0]         kernelX_p0_rd_data;
  logic                kernelX_p0_addr_en;
  logic [KADDR_W-1:0]  kernelX_p0_addr_data;
  logic                kernelX_p0_rd_en;

  logic [31:0]         kernelY_p0_rd_data;
  logic                kernelY_p0_addr_en;
  logic [KADDR_W-1:0]  kernelY_p0_addr_data;
  logic                kernelY_p0_rd_en;

  logic [31:0]         mask_img_p0_wr_data;
  logic                mask_img_p0_addr_en;
  logic [ADDR_W-1:0]   mask_img_p0_addr_data;
  logic                mask_img_p0_wr_en;

  modport master (
    input  img_p0_rd_data,
    output img_p0_addr_en, img_p0_addr_data, img_p0_rd_en,
    input  kernelX_p0_rd_data,
    output kernelX_p0_addr_en, kernelX_p0_addr_data, kernelX_p0_rd_en,
    input  kernelY_p0_rd_data,
    output kernelY_p0_addr_en, kernelY_p0_addr_data, kernelY_p0_rd_en,
    output mask_img_p0_wr_data, mask_img_p0_addr_en, mask_img_p0_addr_data,
           mask_img_p0_wr_en
  );

  modport slave (
    output img_p0_rd_data,
    input  img_p0_addr_en, img_p0_addr_data, img_p0_rd_en,
    output kernelX_p0_rd_data,
    input  kernelX_p0_addr_en, kernelX_p0_addr_data, kernelX_p0_rd_en,
    output kernelY_p0_rd_data,
    input  kernelY_p0_addr_en, kernelY_p0_addr_data, kernelY_p0_rd_en,
    input  mask_img_p0_wr_data, mask_img_p0_addr_en, mask_img_p0_addr_data,
           mask_img_p0_wr_en
  );
endinterface

// File: rtl/unsharp_mask_core.sv
// -----------------------------------------------------------------------------
// unsharp_mask_core
// Purpose : sharpens an IMG_W x IMG_H greyscale image held in an external
//           1-cycle-latency read RAM and writes mask = clamp(2*p - blur)
//           to a write RAM. The blur is a separable KxK convolution whose
//           taps are loaded from the kernelX / kernelY RAMs at every start.
// Ports   :
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset
//   t     in   one-cycle start pulse, honoured only while idle
//   done  out  (only with UNSHARP_DONE_EN) one-cycle pulse in the cycle
//              after the final mask write
//   bus   master side of unsharp_mask_core_if (image / kernel reads,
//         mask writes)
// Config  : define UNSHARP_DONE_EN to add the done output. Without it,
//           completion is visible only through the final write.
// Timing  : LOADK occupies K cycles. Border pixels take 3 cycles
//           (read, data, write); interior pixels take K*K+2 cycles
//           (K*K reads, last data, write).
// -----------------------------------------------------------------------------
module unsharp_mask_core #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int K          = 5,
  parameter int NORM_SHIFT = 8,
  parameter int ADDR_W     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
`ifdef UNSHARP_DONE_EN
  output logic done,
`endif
  unsharp_mask_core_if.master bus
);

  localparam int KADDR_W = 3;
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int COL_W   = $clog2(IMG_W);
  localparam int TAP_W   = $clog2(K);
  localparam int STEP_W  = $clog2(K * K + 2);
  localparam int HALF    = K / 2;

  localparam logic [ROW_W-1:0]  ROW_LO    = ROW_W'(HALF);
  localparam logic [ROW_W-1:0]  ROW_HI    = ROW_W'(IMG_H - 1 - HALF);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]  COL_LO    = COL_W'(HALF);
  localparam logic [COL_W-1:0]  COL_HI    = COL_W'(IMG_W - 1 - HALF);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(K - 1);
  localparam logic [STEP_W-1:0] K_LAST    = STEP_W'(K - 1);
  // Border pixel: read at step 0, data at step 1, write at step 2.
  localparam logic [STEP_W-1:0] B_DATA    = STEP_W'(1);
  localparam logic [STEP_W-1:0] B_WR      = STEP_W'(2);
  // Interior pixel: reads at steps 0..K*K-1, data one step later,
  // write two steps after the last read.
  localparam logic [STEP_W-1:0] I_LAST_RD = STEP_W'(K * K - 1);
  localparam logic [STEP_W-1:0] I_LAST_DT = STEP_W'(K * K);
  localparam logic [STEP_W-1:0] I_WR      = STEP_W'(K * K + 1);
  // The centre is read (HALF*K + HALF) and returns one step later.
  localparam logic [STEP_W-1:0] I_CENTRE  = STEP_W'(HALF * K + HALF + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOADK, S_PIX} state_t;

  state_t r_state, w_state_next;

  logic [STEP_W-1:0]  r_step;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [TAP_W-1:0]   r_dx, r_dy;      // tap of the read issued this cycle
  logic [TAP_W-1:0]   r_pdx, r_pdy;    // tap whose data returns this cycle
  logic [31:0]        r_acc;
  logic [7:0]         r_centre;
  logic [7:0]         r_mask;
  logic [7:0]         r_kx [K];
  logic [7:0]         r_ky [K];
  logic               r_k_pend;
  logic [KADDR_W-1:0] r_k_idx;

  logic               w_border;
  logic               w_last_pixel;
  logic               w_pix_done;
  logic               w_run_end;
  logic               w_k_rd;
  logic               w_img_rd;
  logic               w_accum;
  logic [7:0]         w_pix_in;
  logic [31:0]        w_prod;
  logic [31:0]        w_acc_sum;
  logic [7:0]         w_blur;
  logic signed [10:0] w_diff;
  logic [7:0]         w_mask;
  logic [ADDR_W-1:0]  w_ctr_addr;
  logic [ADDR_W-1:0]  w_tap_row, w_tap_col, w_tap_addr;
  logic               w_unused;

  // ---------------------------------------------------------------------------
  // Pixel classification and step decode
  // ---------------------------------------------------------------------------
  assign w_border     = (r_row < ROW_LO) || (r_row > ROW_HI) ||
                        (r_col < COL_LO) || (r_col > COL_HI);
  assign w_last_pixel = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_pix_done   = (r_state == S_PIX) &&
                        (r_step == (w_border ? B_WR : I_WR));
  assign w_run_end    = w_pix_done && w_last_pixel;

  assign w_k_rd   = (r_state == S_LOADK);
  assign w_img_rd = (r_state == S_PIX) &&
                    (w_border ? (r_step == '0) : (r_step <= I_LAST_RD));
  assign w_accum  = (r_state == S_PIX) && !w_border &&
                    (r_step != '0) && (r_step <= I_LAST_DT);

  // ---------------------------------------------------------------------------
  // Arithmetic: acc += kx*ky*p; blur = acc >> NORM_SHIFT (8 bits);
  // mask = clamp(2*centre - blur, 0, 255)
  // ---------------------------------------------------------------------------
  assign w_pix_in  = bus.img_p0_rd_data[7:0];
  assign w_prod    = 32'(r_kx[r_pdx]) * 32'(r_ky[r_pdy]) * 32'(w_pix_in);
  assign w_acc_sum = r_acc + w_prod;
  assign w_blur    = w_acc_sum[NORM_SHIFT +: 8];
  assign w_diff    = $signed({2'b00, r_centre, 1'b0}) - $signed({3'b000, w_blur});

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_mask = w_diff[7:0];
    if (w_diff[10])
      w_mask = 8'h00;
    else if (|w_diff[9:8])
      w_mask = 8'hFF;
  end

  // ---------------------------------------------------------------------------
  // Addresses. The tap coordinates stay in range for interior pixels, so
  // modular ADDR_W arithmetic gives the exact row*IMG_W + col.
  // ---------------------------------------------------------------------------
  assign w_ctr_addr = ADDR_W'(r_row) * ADDR_W'(IMG_W) + ADDR_W'(r_col);
  assign w_tap_row  = ADDR_W'(r_row) + ADDR_W'(r_dy) - ADDR_W'(HALF);
  assign w_tap_col  = ADDR_W'(r_col) + ADDR_W'(r_dx) - ADDR_W'(HALF);
  assign w_tap_addr = w_tap_row * ADDR_W'(IMG_W) + w_tap_col;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (t)                  w_state_next = S_LOADK;
      S_LOADK: if (r_step == K_LAST)   w_state_next = S_PIX;
      S_PIX:   if (w_run_end)          w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Kernel capture: data returns the cycle after each LOADK read, so the
  // last tap lands during the first PIX cycle, before any image data arrives.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_pend <= 1'b0;
      r_k_idx  <= '0;
      // NOTE: the tap registers are a handful of flops, not a RAM, so they
      // are reset like any other state.
      for (int i = 0; i < K; i++) begin
        r_kx[i] <= '0;
        r_ky[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      r_k_pend <= w_k_rd;
      r_k_idx  <= r_step[KADDR_W-1:0];
      if (r_k_pend) begin
        r_kx[r_k_idx] <= bus.kernelX_p0_rd_data[7:0];
        r_ky[r_k_idx] <= bus.kernelY_p0_rd_data[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel sequencer and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_pdx    <= '0;
      r_pdy    <= '0;
      r_acc    <= '0;
      r_centre <= '0;
      r_mask   <= '0;
    end else begin
      r_pdx <= r_dx;
      r_pdy <= r_dy;
      case (r_state)
        S_IDLE: begin
          r_step <= '0;
          r_row  <= '0;
          r_col  <= '0;
          r_dx   <= '0;
          r_dy   <= '0;
          r_acc  <= '0;
        end
        S_LOADK: begin
          r_step <= (r_step == K_LAST) ? '0 : r_step + 1'b1;
        end
        S_PIX: begin
          if (w_pix_done) begin
            r_step <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
            r_acc  <= '0;
            if (r_col == COL_LAST) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end else begin
            r_step <= r_step + 1'b1;
            if (w_border) begin
              // Border pixels are copied through unchanged.
              if (r_step == B_DATA)
                r_mask <= w_pix_in;
            end else begin
              // Hold the tap at (K-1,K-1) after the last read so the
              // kernel index never leaves 0..K-1.
              if (w_img_rd && (r_step != I_LAST_RD)) begin
                if (r_dx == TAP_LAST) begin
                  r_dx <= '0;
                  r_dy <= r_dy + 1'b1;
                end else begin
                  r_dx <= r_dx + 1'b1;
                end
              end
              if (w_accum)
                r_acc <= w_acc_sum;
              if (r_step == I_CENTRE)
                r_centre <= w_pix_in;
              if (r_step == I_LAST_DT)
                r_mask <= w_mask;
            end
          end
        end
        default: r_step <= '0;
      endcase
    end
  end

`ifdef UNSHARP_DONE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      done <= 1'b0;
    else
      done <= w_run_end;
  end
`else
  // No done port: the final mask write marks completion.
`endif

  // ---------------------------------------------------------------------------
  // Bus outputs: address and enables move together and idle at zero.
  // ---------------------------------------------------------------------------
  assign bus.img_p0_rd_en         = w_img_rd;
  assign bus.img_p0_addr_en       = w_img_rd;
  assign bus.img_p0_addr_data     = w_img_rd ? (w_border ? w_ctr_addr : w_tap_addr) : '0;

  assign bus.kernelX_p0_rd_en     = w_k_rd;
  assign bus.kernelX_p0_addr_en   = w_k_rd;
  assign bus.kernelX_p0_addr_data = w_k_rd ? r_step[KADDR_W-1:0] : '0;
  assign bus.kernelY_p0_rd_en     = w_k_rd;
  assign bus.kernelY_p0_addr_en   = w_k_rd;
  assign bus.kernelY_p0_addr_data = w_k_rd ? r_step[KADDR_W-1:0] : '0;

  assign bus.mask_img_p0_wr_en     = w_pix_done;
  assign bus.mask_img_p0_addr_en   = w_pix_done;
  assign bus.mask_img_p0_addr_data = w_pix_done ? w_ctr_addr : '0;
  assign bus.mask_img_p0_wr_data   = w_pix_done ? {24'h000000, r_mask} : '0;

  // Upper read-data bits and the accumulator bits outside the blur window
  // carry no information for this function.
  assign w_unused = ^{bus.img_p0_rd_data[31:8], bus.kernelX_p0_rd_data[31:8],
                      bus.kernelY_p0_rd_data[31:8], w_acc_sum[31:NORM_SHIFT+8],
                      w_acc_sum[NORM_SHIFT-1:0]};

endmodule

// File: tb/tb_unsharp_mask_core.sv
// -----------------------------------------------------------------------------
// tb_unsharp_mask_core
// Bench for unsharp_mask_core: RAM models on the slave side of the bus
// interface, an arithmetic reference model of the sharpening rule, and a
// write monitor that pops expected (address, data) pairs from a queue.
// -----------------------------------------------------------------------------
module tb_unsharp_mask_core;

  localparam int W = 32;
  localparam int H = 32;
  localparam int N = W * H;
  // LOADK in cycles 1..5, then 240 border pixels x 3 + 784 interior x 27.
  localparam int LAST_WR_REL = 5 + 240 * 3 + 784 * 27;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t   = 1'b0;
`ifdef UNSHARP_DONE_EN
  logic done;
`endif

  always #5 clk = ~clk;

  unsharp_mask_core_if #(.ADDR_W(10), .KADDR_W(3)) bus ();

  unsharp_mask_core dut (
    .clk  (clk),
    .rst  (rst),
    .t    (t),
`ifdef UNSHARP_DONE_EN
    .done (done),
`endif
    .bus  (bus)
  );

  logic [31:0] img_mem  [N];
  logic [31:0] mask_mem [N];
  logic [31:0] kx_mem   [8];
  logic [31:0] ky_mem   [8];

  wr_t exp_q[$];
  int  n_checks  = 0;
  int  n_errors  = 0;
  int  cyc       = 0;
  int  t_cyc     = 0;
  int  wr_count  = 0;
  int  last_wr_rel = -1;
  int  done_count  = 0;
  int  done_rel    = -1;

  // 1-cycle-latency RAM models.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.img_p0_rd_en)     bus.img_p0_rd_data     <= img_mem[bus.img_p0_addr_data];
    if (bus.kernelX_p0_rd_en) bus.kernelX_p0_rd_data <= kx_mem[bus.kernelX_p0_addr_data];
    if (bus.kernelY_p0_rd_en) bus.kernelY_p0_rd_data <= ky_mem[bus.kernelY_p0_addr_data];
    if (bus.mask_img_p0_wr_en) mask_mem[bus.mask_img_p0_addr_data] <= bus.mask_img_p0_wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: border pixels copy through; interior pixels are
  // clamp(2p - ((sum kx*ky*p) >> 8 mod 256), 0, 255).
  function automatic logic [7:0] model_px(input int r, input int c);
    int p, acc, blur, diff;
    p = int'(img_mem[r * W + c][7:0]);
    if (r < 2 || r > H - 3 || c < 2 || c > W - 3) return 8'(p);
    acc = 0;
    for (int dy = -2; dy <= 2; dy++)
      for (int dx = -2; dx <= 2; dx++)
        acc += int'(kx_mem[dx + 2][7:0]) * int'(ky_mem[dy + 2][7:0]) *
               int'(img_mem[(r + dy) * W + (c + dx)][7:0]);
    blur = (acc >> 8) & 255;
    diff = 2 * p - blur;
    if (diff < 0)   return 8'd0;
    if (diff > 255) return 8'd255;
    return 8'(diff);
  endfunction

  task automatic load_expected();
    wr_t e;
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        e.addr = 10'(r * W + c);
        e.data = {24'h0, model_px(r, c)};
        exp_q.push_back(e);
      end
    for (int i = 0; i < N; i++) mask_mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic set_kernel(input bit randomize_taps);
    logic [7:0] binom [5];
    binom[0] = 8'd1; binom[1] = 8'd4; binom[2] = 8'd6; binom[3] = 8'd4; binom[4] = 8'd1;
    for (int i = 0; i < 8; i++) begin
      kx_mem[i] = $urandom();
      ky_mem[i] = $urandom();
      if (i < 5 && !randomize_taps) begin
        kx_mem[i][7:0] = binom[i];
        ky_mem[i][7:0] = binom[i];
      end
    end
  endtask

  task automatic fill_image(input int mode);
    for (int i = 0; i < N; i++) begin
      img_mem[i] = $urandom();  // upper bits are noise the core must ignore
      case (mode)
        0: img_mem[i][7:0] = 8'd100;
        1: img_mem[i][7:0] = (i == 16 * W + 16) ? 8'd255 : 8'd0;
        default: ;
      endcase
    end
  endtask

  task automatic pulse_t();
    #1 t = 1'b1;
    @(posedge clk);
    #1 t = 1'b0;
  endtask

  task automatic start_run();
    @(posedge clk);
    #1 t = 1'b1;
    t_cyc      = cyc;
    wr_count   = 0;
    done_count = 0;
    last_wr_rel = -1;
    done_rel    = -1;
    @(posedge clk);
    #1 t = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    for (int i = 0; i < 25000 && wr_count < N; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check({tag, "_write_count"}, wr_count, N);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_last_write_cycle"}, last_wr_rel, LAST_WR_REL);
`ifdef UNSHARP_DONE_EN
    check({tag, "_done_pulses"}, done_count, 1);
    check({tag, "_done_cycle"}, done_rel, LAST_WR_REL + 1);
`endif
    check({tag, "_idle_img_rd"}, bus.img_p0_rd_en, 0);
    check({tag, "_idle_wr_en"}, bus.mask_img_p0_wr_en, 0);
  endtask

  // Write monitor: pops and compares every mask write.
  always @(negedge clk) begin
    if (!rst && bus.mask_img_p0_wr_en) begin
      wr_count++;
      last_wr_rel = cyc - t_cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                 bus.mask_img_p0_addr_data, bus.mask_img_p0_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mask_img_p0_addr_data), 32'(e.addr));
        check("wr_data", bus.mask_img_p0_wr_data, e.data);
        check("wr_addr_en", 32'(bus.mask_img_p0_addr_en), 1);
      end
    end
`ifdef UNSHARP_DONE_EN
    if (!rst && done) begin
      done_count++;
      done_rel = cyc - t_cyc;
    end
`endif
  end

  task automatic check_strobes_low(input string tag);
    check({tag, "_img_rd_en"}, bus.img_p0_rd_en, 0);
    check({tag, "_img_addr"}, 32'(bus.img_p0_addr_data), 0);
    check({tag, "_kx_rd_en"}, bus.kernelX_p0_rd_en, 0);
    check({tag, "_ky_rd_en"}, bus.kernelY_p0_rd_en, 0);
    check({tag, "_wr_en"}, bus.mask_img_p0_wr_en, 0);
    check({tag, "_wr_data"}, bus.mask_img_p0_wr_data, 0);
`ifdef UNSHARP_DONE_EN
    check({tag, "_done"}, done, 0);
`endif
  endtask

  initial begin
    int bad;

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_strobes_low("reset");
    rst = 1'b0;

    // Run A: constant image, binomial kernel, start-sequence timing
    set_kernel(1'b0);
    fill_image(0);
    load_expected();
    start_run();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("start_kx_rd_%0d", k), bus.kernelX_p0_rd_en, 1);
      check($sformatf("start_kx_addr_%0d", k), 32'(bus.kernelX_p0_addr_data), k);
      check($sformatf("start_kx_addr_en_%0d", k), bus.kernelX_p0_addr_en, 1);
      check($sformatf("start_ky_rd_%0d", k), bus.kernelY_p0_rd_en, 1);
      check($sformatf("start_ky_addr_%0d", k), 32'(bus.kernelY_p0_addr_data), k);
      check($sformatf("start_img_rd_%0d", k), bus.img_p0_rd_en, 0);
    end
    @(negedge clk);
    check("start_first_img_rd", bus.img_p0_rd_en, 1);
    check("start_first_img_addr", 32'(bus.img_p0_addr_data), 0);
    check("start_first_img_addr_en", bus.img_p0_addr_en, 1);
    check("start_kx_done", bus.kernelX_p0_rd_en, 0);
    wait_run("const");
    bad = 0;
    for (int i = 0; i < N; i++) if (mask_mem[i] !== 32'd100) bad++;
    check("const_words_not_100", bad, 0);

    // Run B: impulse
    fill_image(1);
    load_expected();
    start_run();
    wait_run("impulse");
    check("impulse_16_16", mask_mem[16 * W + 16], 255);
    check("impulse_16_17", mask_mem[16 * W + 17], 0);
    check("impulse_10_10", mask_mem[10 * W + 10], 0);

    // Run C: random image, reset asserted mid-run in cycle 1000
    set_kernel(1'b1);
    fill_image(2);
    load_expected();
    start_run();
    while (cyc - t_cyc < 1000) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_strobes_low("midrun_reset");
    repeat (3) @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;

    // Run D: fresh random image and kernel, extra t pulses while busy
    set_kernel(1'b1);
    fill_image(2);
    load_expected();
    start_run();
    @(posedge clk);
    pulse_t();                       // lands in LOADK
    fork
      begin
        repeat (8) begin
          repeat ($urandom_range(100, 2500)) @(posedge clk);
          if (cyc - t_cyc < LAST_WR_REL - 100) pulse_t();
        end
      end
      wait_run("random");
    join
    bad = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if ((r < 2 || r > H - 3 || c < 2 || c > W - 3) &&
            mask_mem[r * W + c] !== {24'h0, img_mem[r * W + c][7:0]})
          bad++;
    check("random_border_not_copied", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
